tape_player: RTL and testbench

//  Plays a cassette image held in the tape buffer back as a Lynx-format square-wave
//  "ear" bitstream feeding the lynx48 core's ear input, so the ROM LOAD routine can read it.

---
 rtl/tape_player.sv | 167 ++++++++++++++++
 tb/tb_tape_player.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_player.sv
// Cassette playback engine: streams the tape buffer out as a Lynx ear square wave
// (leader pulses, one sync pulse, then bytes MSB-first), paced by ce and gated by motor.
module tape_player #(
   parameter int AW     = 16,
   parameter int HALF0  = 4,
   parameter int HALF1  = 8,
   parameter int SYNCH  = 12,
   parameter int LEADER = 768
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          ce,
   input  logic          start,
   input  logic          stop,
   input  logic          motor,
   input  logic [AW-1:0] len,
   output logic [AW-1:0] rd_addr,
   input  logic [7:0]    rd_data,
   output logic          ear,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] pos,
   output logic [3:0]    dbg_state
);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      LEAD_H = 4'd1,
      LEAD_L = 4'd2,
      SYNC_H = 4'd3,
      SYNC_L = 4'd4,
      FETCH0 = 4'd5,
      FETCH1 = 4'd6,
      BIT_H  = 4'd7,
      BIT_L  = 4'd8,
      TAIL   = 4'd9
   } state_t;

   state_t        state, state_nxt;
   logic [15:0]   tick_cnt, tick_load;
   logic [15:0]   pulse_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;
   logic [AW-1:0] len_q, pos_q;
   logic          done_q;
   logic          timed, tick_end, last_byte;

   // Control is pulse-based: start is taken only in IDLE, stop is taken in any state
   // and overrides start; there is no back-pressure on either.
   assign timed     = (state != IDLE) && (state != FETCH0) && (state != FETCH1);
   assign tick_end  = timed && ce && motor && (tick_cnt == 16'd0);
   assign last_byte = (pos_q == len_q - AW'(1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (stop) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:   if (start && (len != '0)) state_nxt = LEAD_H;
            LEAD_H: if (tick_end) state_nxt = LEAD_L;
            LEAD_L: if (tick_end) state_nxt = (pulse_cnt != 16'd0) ? LEAD_H : SYNC_H;
            SYNC_H: if (tick_end) state_nxt = SYNC_L;
            SYNC_L: if (tick_end) state_nxt = FETCH0;
            FETCH0: state_nxt = FETCH1;
            FETCH1: state_nxt = BIT_H;
            BIT_H:  if (tick_end) state_nxt = BIT_L;
            BIT_L: begin
               if (tick_end) begin
                  if (bit_cnt != 3'd0) state_nxt = BIT_H;
                  else if (!last_byte) state_nxt = FETCH0;
                  else                 state_nxt = TAIL;
               end
            end
            TAIL:   if (tick_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Half-length of the phase being entered; the first bit of a byte comes straight
   // from the buffer, later bits from the shift register before it shifts.
   always_comb begin
      tick_load = 16'd0;
      case (state_nxt)
         LEAD_H, LEAD_L, TAIL: tick_load = 16'(HALF0 - 1);
         SYNC_H, SYNC_L:       tick_load = 16'(SYNCH - 1);
         BIT_H: begin
            if ((state == FETCH1) ? rd_data[7] : shift_reg[6]) tick_load = 16'(HALF1 - 1);
            else                                                tick_load = 16'(HALF0 - 1);
         end
         BIT_L: tick_load = shift_reg[7] ? 16'(HALF1 - 1) : 16'(HALF0 - 1);
         default: tick_load = 16'd0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tick_cnt  <= 16'd0;
         pulse_cnt <= 16'd0;
         bit_cnt   <= 3'd0;
         shift_reg <= 8'd0;
         len_q     <= '0;
         pos_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_nxt != state)
            tick_cnt <= tick_load;
         else if (timed && ce && motor && (tick_cnt != 16'd0))
            tick_cnt <= tick_cnt - 16'd1;
         if (!stop) begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (len != '0) begin
                        len_q     <= len;
                        pos_q     <= '0;
                        pulse_cnt <= 16'(LEADER - 1);
                     end else begin
                        done_q <= 1'b1;
                     end
                  end
               end
               LEAD_L: if (tick_end && (pulse_cnt != 16'd0)) pulse_cnt <= pulse_cnt - 16'd1;
               FETCH1: begin
                  shift_reg <= rd_data;
                  bit_cnt   <= 3'd7;
               end
               BIT_L: begin
                  if (tick_end) begin
                     if (bit_cnt != 3'd0) begin
                        shift_reg <= {shift_reg[6:0], 1'b0};
                        bit_cnt   <= bit_cnt - 3'd1;
                     end else if (!last_byte) begin
                        pos_q <= pos_q + AW'(1);
                     end
                  end
               end
               TAIL: if (tick_end) done_q <= 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      ear  = 1'b0;
      busy = 1'b1;
      case (state)
         LEAD_H, SYNC_H, BIT_H: ear = 1'b1;
         IDLE:                  busy = 1'b0;
         default: ;
      endcase
   end

   assign done      = done_q;
   assign pos       = pos_q;
   assign rd_addr   = pos_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_tape_player.sv
// Bench for tape_player: vector table plus random runs against a segment-level model
// of the ear waveform, and hand-written reset / stop / motor / zero-length sequences.
module tb_tape_player;
   localparam int AW = 16, HALF0 = 2, HALF1 = 4, SYNCH = 6, LEADER = 3;
   localparam logic [3:0] ST_IDLE = 4'd0, ST_SYNC_H = 4'd3, ST_FETCH0 = 4'd5, ST_BIT_H = 4'd7;
   localparam int BUDGET = 4000;

   logic          clock = 1'b0, reset = 1'b0, ce = 1'b0;
   logic          start = 1'b0, stop = 1'b0, motor = 1'b1;
   logic [AW-1:0] len = '0;
   logic [AW-1:0] rd_addr, pos;
   logic [7:0]    rd_data;
   logic          ear, busy, done;
   logic [3:0]    dbg_state;

   logic [7:0]    mem [0:255];
   logic [0:0]    exp_q [$];
   logic [0:0]    obs_q [$];
   logic [AW-1:0] addr_q [$];
   int            tests = 0, fails = 0;
   int            done_cnt = 0, done_busy_bad = 0, ce_div = 0;
   logic          mon_en = 1'b0;

   typedef struct {
      int          n;
      logic [31:0] data;
      int          ticks;
      int          last;
      int          mode;
   } vec_t;
   vec_t vt [5];

   tape_player #(.AW(AW), .HALF0(HALF0), .HALF1(HALF1), .SYNCH(SYNCH), .LEADER(LEADER)) dut (
      .clock(clock), .reset(reset), .ce(ce), .start(start), .stop(stop), .motor(motor),
      .len(len), .rd_addr(rd_addr), .rd_data(rd_data), .ear(ear), .busy(busy),
      .done(done), .pos(pos), .dbg_state(dbg_state)
   );

   always #5 clock = ~clock;

   always @(posedge clock) rd_data <= mem[rd_addr[7:0]];

   // ce every 4th clock; ear is recorded for each ce the DUT will count (busy, motor on)
   always @(negedge clock) begin
      if (done) begin
         done_cnt++;
         if (busy) done_busy_bad++;
      end
      if (mon_en && dbg_state == ST_FETCH0) addr_q.push_back(rd_addr);
      ce_div = (ce_div + 1) % 4;
      if (ce_div == 0) begin
         ce = 1'b1;
         if (mon_en && busy && motor) obs_q.push_back(ear);
      end else begin
         ce = 1'b0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_half(input logic lvl, input int t);
      for (int i = 0; i < t; i++) exp_q.push_back(lvl);
   endtask

   // Expected ear level at every counted ce tick, from the format rules alone
   task automatic build_exp(input int n);
      exp_q.delete();
      for (int p = 0; p < LEADER; p++) begin
         push_half(1'b1, HALF0);
         push_half(1'b0, HALF0);
      end
      push_half(1'b1, SYNCH);
      push_half(1'b0, SYNCH);
      for (int k = 0; k < n; k++) begin
         for (int b = 7; b >= 0; b--) begin
            int h;
            h = mem[k][b] ? HALF1 : HALF0;
            push_half(1'b1, h);
            push_half(1'b0, h);
         end
      end
      push_half(1'b0, HALF0);
   endtask

   task automatic chk_stream(input string name);
      int bad;
      bad = -1;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
      tests++;
      if (bad >= 0 || obs_q.size() != exp_q.size()) begin
         fails++;
         $display("FAIL %s: got %0d ticks expected %0d ticks, first differing tick %0d",
                  name, obs_q.size(), exp_q.size(), bad);
      end
   endtask

   task automatic load_mem(input logic [31:0] data);
      for (int k = 0; k < 4; k++) mem[k] = data[31-8*k -: 8];
   endtask

   // mode 0: plain, 1: motor off for 10 ce in SYNC_H, 2: start with new len while busy
   task automatic run_play(input int n, input int mode);
      int   cycles, held_bad;
      logic paused;
      obs_q.delete();
      addr_q.delete();
      done_cnt = 0;
      done_busy_bad = 0;
      held_bad = 0;
      paused = 1'b0;
      build_exp(n);
      @(posedge clock); #1;
      len = AW'(n);
      start = 1'b1;
      mon_en = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      cycles = 0;
      while (done_cnt == 0 && cycles < BUDGET) begin
         if (mode == 1 && !paused && dbg_state == ST_SYNC_H) begin
            paused = 1'b1;
            motor = 1'b0;
            repeat (40) begin
               @(posedge clock); #1;
               if (ear !== 1'b1) held_bad++;
            end
            chk("pause_state_held", dbg_state, ST_SYNC_H);
            chk("pause_ear_high", held_bad, 0);
            motor = 1'b1;
         end
         if (mode == 2 && cycles == 100) begin
            len = AW'(7);
            start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
         end
         @(posedge clock); #1;
         cycles++;
      end
      mon_en = 1'b0;
      chk("play_timeout", (cycles < BUDGET), 1);
      if (mode == 1) chk("pause_reached", paused, 1);
      chk("busy_after_done", busy, 0);
      chk("ear_after_done", ear, 0);
      repeat (3) @(posedge clock);
      #1;
      chk("done_once", done_cnt, 1);
      chk("done_while_busy", done_busy_bad, 0);
      chk_stream("ear_stream");
   endtask

   task automatic chk_addrs(input int n);
      chk("fetch_count", addr_q.size(), n);
      for (int k = 0; k < n && k < addr_q.size(); k++) chk("fetch_addr", addr_q[k], k);
   endtask

   initial begin
      int k, rises, n, mode;
      logic prev;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      vt[0] = '{n: 1, data: 32'hA5000000, ticks: 74,  last: 0, mode: 0};
      vt[1] = '{n: 3, data: 32'h00FF8100, ticks: 162, last: 2, mode: 1};
      vt[2] = '{n: 2, data: 32'h0FF00000, ticks: 122, last: 1, mode: 2};
      vt[3] = '{n: 1, data: 32'h00000000, ticks: 58,  last: 0, mode: 0};
      vt[4] = '{n: 4, data: 32'h01020480, ticks: 170, last: 3, mode: 0};

      repeat (3) @(posedge clock);
      #1;
      chk("rst_ear", ear, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_pos", pos, 0);
      chk("rst_state", dbg_state, ST_IDLE);
      reset = 1'b1;

      for (int v = 0; v < 5; v++) begin
         load_mem(vt[v].data);
         run_play(vt[v].n, vt[v].mode);
         chk("vec_ticks", obs_q.size(), vt[v].ticks);
         chk("vec_pos", pos, vt[v].last);
         chk_addrs(vt[v].n);
      end

      // asynchronous reset in the middle of byte 1
      load_mem(32'h00FF8100);
      @(posedge clock); #1;
      len = AW'(3);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      k = 0;
      while (!(pos == AW'(1) && dbg_state == ST_BIT_H) && k < BUDGET) begin
         @(posedge clock); #1;
         k++;
      end
      chk("arst_reach", (k < BUDGET), 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_ear", ear, 0);
      chk("arst_busy", busy, 0);
      chk("arst_rd_addr", rd_addr, 0);
      chk("arst_pos", pos, 0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      chk("arst_idle", dbg_state, ST_IDLE);

      // stop at byte 1 bit 3, then a full replay from byte 0
      done_cnt = 0;
      len = AW'(3);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      k = 0;
      while (pos != AW'(1) && k < BUDGET) begin
         @(posedge clock); #1;
         k++;
      end
      rises = 0;
      prev = ear;
      while (rises < 4 && k < BUDGET) begin
         @(posedge clock); #1;
         if (ear && !prev) rises++;
         prev = ear;
         k++;
      end
      chk("stop_reach", (k < BUDGET), 1);
      stop = 1'b1;
      @(posedge clock); #1;
      stop = 1'b0;
      chk("stop_state", dbg_state, ST_IDLE);
      chk("stop_ear", ear, 0);
      chk("stop_busy", busy, 0);
      repeat (50) @(posedge clock);
      #1;
      chk("stop_no_done", done_cnt, 0);
      run_play(3, 0);
      chk("replay_pos", pos, 2);
      chk_addrs(3);

      // zero-length start, then start and stop together
      done_cnt = 0;
      len = '0;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      chk("len0_done", done, 1);
      chk("len0_busy", busy, 0);
      chk("len0_ear", ear, 0);
      @(posedge clock); #1;
      chk("len0_done_clear", done, 0);
      chk("len0_state", dbg_state, ST_IDLE);
      done_cnt = 0;
      len = AW'(2);
      start = 1'b1;
      stop = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      stop = 1'b0;
      chk("startstop_state", dbg_state, ST_IDLE);
      chk("startstop_busy", busy, 0);
      repeat (10) @(posedge clock);
      #1;
      chk("startstop_no_done", done_cnt, 0);

      // random images against the model
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(1, 5);
         mode = $urandom_range(0, 2);
         for (int j = 0; j < n; j++) mem[j] = 8'($urandom_range(0, 255));
         run_play(n, mode);
         chk("rnd_pos", pos, n - 1);
         chk_addrs(n);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
